// File: rtl/bist_ora_misr.sv
// bist_ora_misr: run-controlled 16-bit MISR over ALU results; BIST_ORA_SELFCHECK_EN adds the GOLDEN verdict
module bist_ora_misr #(
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter int PATTERNS = 255,
  parameter int WARMUP = 2,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sum,
  input  logic        cout,
  input  logic [7:0]  sub,
  input  logic        borrow,
  input  logic [15:0] mul,
  input  logic [7:0]  out_xor,
  input  logic [7:0]  out_xnor,
  input  logic [7:0]  out_nand,
  input  logic [7:0]  out_ll,
  input  logic [7:0]  out_lr,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] pat_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_WARM, S_COMP, S_DONE} state_t;
  state_t state;
  logic [3:0] wcnt;
  logic [79:0] v;
  logic [15:0] fold, sig_next;
  logic hit;
  assign v = {6'b0, cout, borrow, mul, sum, sub, out_xor, out_xnor, out_nand, out_ll, out_lr};
  assign fold = v[15:0] ^ v[31:16] ^ v[47:32] ^ v[63:48] ^ v[79:64];
  assign sig_next = {signature[14:0], signature[15] ^ signature[11] ^ signature[2] ^ signature[0]} ^ fold;
`ifdef BIST_ORA_SELFCHECK_EN
  assign hit = sig_next == GOLDEN;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      signature <= SEED;
      pat_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      wcnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          signature <= SEED;
          pat_cnt <= '0;
          done <= 1'b0;
          pass <= 1'b0;
          busy <= 1'b1;
          wcnt <= '0;
          state <= (WARMUP == 0) ? S_COMP : S_WARM;
        end
        S_WARM: begin
          wcnt <= wcnt + 4'd1;
          if (wcnt == 4'(WARMUP - 1)) state <= S_COMP;
        end
        S_COMP: begin
          signature <= sig_next;
          pat_cnt <= pat_cnt + 16'd1;
          if (pat_cnt == 16'(PATTERNS - 1)) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= hit;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bist_ora_misr.sv
// tb_bist_ora_misr: scoreboarded checks of three differently parameterised analyzers
module tb_bist_ora_misr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] start_a = '0;
  logic [7:0] sum, sub, out_xor, out_xnor, out_nand, out_ll, out_lr;
  logic cout, borrow;
  logic [15:0] mul;
  logic [2:0] busy_a, done_a, pass_a;
  logic [15:0] sig_a [3];
  logic [15:0] cnt_a [3];
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;
`ifdef BIST_ORA_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  always #5 clk = ~clk;

  bist_ora_misr #(.SEED(16'hFFFF), .PATTERNS(3), .WARMUP(2), .GOLDEN(16'h0000)) d0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .sum(sum), .cout(cout), .sub(sub),
    .borrow(borrow), .mul(mul), .out_xor(out_xor), .out_xnor(out_xnor), .out_nand(out_nand),
    .out_ll(out_ll), .out_lr(out_lr), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
    .signature(sig_a[0]), .pat_cnt(cnt_a[0]));
  bist_ora_misr #(.SEED(16'h0001), .PATTERNS(1), .WARMUP(0), .GOLDEN(16'h0000)) d1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .sum(sum), .cout(cout), .sub(sub),
    .borrow(borrow), .mul(mul), .out_xor(out_xor), .out_xnor(out_xnor), .out_nand(out_nand),
    .out_ll(out_ll), .out_lr(out_lr), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
    .signature(sig_a[1]), .pat_cnt(cnt_a[1]));
  bist_ora_misr #(.SEED(16'h0000), .PATTERNS(1), .WARMUP(0), .GOLDEN(16'h0001)) d2 (
    .clk(clk), .reset(reset), .start(start_a[2]), .sum(sum), .cout(cout), .sub(sub),
    .borrow(borrow), .mul(mul), .out_xor(out_xor), .out_xnor(out_xnor), .out_nand(out_nand),
    .out_ll(out_ll), .out_lr(out_lr), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]),
    .signature(sig_a[2]), .pat_cnt(cnt_a[2]));

  function automatic logic [15:0] seed_of(input int id);
    return id == 0 ? 16'hFFFF : id == 1 ? 16'h0001 : 16'h0000;
  endfunction

  function automatic logic [15:0] fold_now();
    logic [79:0] v;
    v = {6'b0, cout, borrow, mul, sum, sub, out_xor, out_xnor, out_nand, out_ll, out_lr};
    return v[15:0] ^ v[31:16] ^ v[47:32] ^ v[63:48] ^ v[79:64];
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] f);
    return {s[14:0], s[15] ^ s[11] ^ s[2] ^ s[0]} ^ f;
  endfunction

  task automatic zero_inputs();
    {sum, sub, out_xor, out_xnor, out_nand, out_ll, out_lr, cout, borrow, mul} = '0;
  endtask

  task automatic gen_inputs(input int salt, input int i);
    logic [31:0] a, b;
    a = salt * 32'h9E3779B1 + i * 32'h85EBCA77;
    a = a ^ (a >> 13);
    b = a * 32'hC2B2AE35 + 32'h27D4EB2F;
    b = b ^ (b >> 15);
    {sum, sub, out_xor, out_xnor} = a;
    {out_nand, out_ll, mul[7:0], out_lr} = b;
    mul[15:8] = a[7:0] ^ b[31:24];
    cout = b[5];
    borrow = a[19];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run; pushes the model's final signature once stimulus is complete.
  task automatic do_run(input int id, input int w, input int p, input int salt, input bit pulse,
                        output int bc);
    logic [15:0] s;
    s = seed_of(id);
    bc = 0;
    if (salt != 0) gen_inputs(salt, 1000);
    start_a[id] = 1'b1;
    tick();
    start_a[id] = 1'b0;
    checks++;
    if (sig_a[id] !== seed_of(id) || done_a[id] !== 1'b0 || busy_a[id] !== 1'b1 || cnt_a[id] !== 16'd0) begin
      failures++;
      $display("FAIL start_load d%0d: sig=%h done=%b busy=%b cnt=%0d want sig=%h done=0 busy=1 cnt=0",
               id, sig_a[id], done_a[id], busy_a[id], cnt_a[id], seed_of(id));
    end
    for (int i = 0; i < w + p; i++) begin
      if (salt != 0) gen_inputs(salt, i);
      if (i >= w) s = misr(s, fold_now());
      start_a[id] = pulse && i == w + 1;
      if (busy_a[id]) bc++;
      tick();
    end
    start_a[id] = 1'b0;
    exp_q.push_back(s);
    checks++;
    if (done_a[id] !== 1'b1 || busy_a[id] !== 1'b0 || cnt_a[id] !== 16'(p)) begin
      failures++;
      $display("FAIL run_end d%0d: done=%b busy=%b cnt=%0d want done=1 busy=0 cnt=%0d",
               id, done_a[id], busy_a[id], cnt_a[id], p);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    zero_inputs();
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sig_a[k] !== seed_of(k) || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 ||
          cnt_a[k] !== 16'd0 || pass_a[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset d%0d: sig=%h busy=%b done=%b cnt=%0d pass=%b want sig=%h, rest 0",
                 k, sig_a[k], busy_a[k], done_a[k], cnt_a[k], pass_a[k], seed_of(k));
      end
    end
  endtask

  task automatic test_min_run();
    int bc;
    logic [15:0] e;
    zero_inputs();
    do_run(1, 0, 1, 0, 1'b0, bc);
    e = exp_q.pop_front();
    checks++;
    if (sig_a[1] !== e || sig_a[1] !== 16'h0003) begin
      failures++;
      $display("FAIL min_run: sig=%h want %h (model %h)", sig_a[1], 16'h0003, e);
    end
    checks++;
    if (bc != 1) begin
      failures++;
      $display("FAIL min_busy: busy cycles=%0d want 1", bc);
    end
  endtask

  task automatic test_golden();
    int bc;
    logic [15:0] e;
    zero_inputs();
    out_lr = 8'h01;
    do_run(2, 0, 1, 0, 1'b0, bc);
    e = exp_q.pop_front();
    checks++;
    if (sig_a[2] !== e || sig_a[2] !== 16'h0001) begin
      failures++;
      $display("FAIL golden_sig: sig=%h want %h (model %h)", sig_a[2], 16'h0001, e);
    end
    checks++;
    if (pass_a[2] !== SELFCHECK) begin
      failures++;
      $display("FAIL golden_pass: pass=%b want %b", pass_a[2], SELFCHECK);
    end
    checks++;
    if (pass_a[1] !== 1'b0) begin
      failures++;
      $display("FAIL golden_miss: pass=%b want 0", pass_a[1]);
    end
    zero_inputs();
  endtask

  task automatic test_warmup();
    int bc;
    logic [15:0] e;
    do_run(0, 2, 3, 5, 1'b0, bc);
    e = exp_q.pop_front();
    checks++;
    if (bc != 5) begin
      failures++;
      $display("FAIL warm_busy: busy cycles=%0d want 5", bc);
    end
    checks++;
    if (sig_a[0] !== e) begin
      failures++;
      $display("FAIL warm_sig: sig=%h want %h", sig_a[0], e);
    end
    checks++;
    if (pass_a[0] !== (SELFCHECK && e == 16'h0000)) begin
      failures++;
      $display("FAIL warm_pass: pass=%b want %b", pass_a[0], SELFCHECK && e == 16'h0000);
    end
  endtask

  task automatic test_start_ignored();
    int bc;
    logic [15:0] e;
    do_run(0, 2, 3, 9, 1'b1, bc);
    e = exp_q.pop_front();
    checks++;
    if (bc != 5 || sig_a[0] !== e) begin
      failures++;
      $display("FAIL start_mid: busy cycles=%0d sig=%h want 5 cycles sig=%h", bc, sig_a[0], e);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    logic [15:0] e1, e2;
    do_run(0, 2, 3, 13, 1'b0, bc);
    e1 = exp_q.pop_front();
    checks++;
    if (sig_a[0] !== e1) begin
      failures++;
      $display("FAIL rerun_first: sig=%h want %h", sig_a[0], e1);
    end
    do_run(0, 2, 3, 13, 1'b0, bc);
    e2 = exp_q.pop_front();
    checks++;
    if (sig_a[0] !== e1 || sig_a[0] !== e2) begin
      failures++;
      $display("FAIL rerun_second: sig=%h want %h", sig_a[0], e1);
    end
  endtask

  task automatic test_reset_mid();
    start_a[0] = 1'b1;
    gen_inputs(21, 0);
    tick();
    start_a[0] = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy_a[0] !== 1'b1 || cnt_a[0] !== 16'd1) begin
      failures++;
      $display("FAIL mid_state: busy=%b cnt=%0d want busy=1 cnt=1", busy_a[0], cnt_a[0]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sig_a[0] !== 16'hFFFF || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 ||
        pass_a[0] !== 1'b0 || cnt_a[0] !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: sig=%h busy=%b done=%b pass=%b cnt=%0d want FFFF 0 0 0 0",
               sig_a[0], busy_a[0], done_a[0], pass_a[0], cnt_a[0]);
    end
    tick();
    checks++;
    if (busy_a[0] !== 1'b0 || sig_a[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_idle: busy=%b sig=%h want 0 FFFF", busy_a[0], sig_a[0]);
    end
  endtask

  initial begin
    test_reset();
    test_min_run();
    test_golden();
    test_warmup();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
